// File: rtl/pwm_sequencer_if.sv
// Configuration handshake bundle for pwm_sequencer.
//   cfg_valid  : new configuration offered (master -> slave)
//   cfg_ready  : configuration slot free (slave -> master)
//   cfg_period : requested carrier terminal count
//   cfg_sel    : requested waveform select
interface pwm_sequencer_if #(
  parameter int unsigned W = 8
);
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_period;
  logic [1:0]   cfg_sel;

  modport master (
    output cfg_valid,
    output cfg_period,
    output cfg_sel,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_period,
    input  cfg_sel,
    output cfg_ready
  );
endinterface

// File: rtl/pwm_sequencer.sv
// Sawtooth-carrier PWM sequencer with shadowed period/select configuration.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   en        : run request (level)
//   cfg       : configuration handshake (pwm_sequencer_if.slave)
//   ref_in    : reference sample, latched on wrap and on start
//   carrier   : sawtooth carrier value
//   sel_out   : active waveform select
//   wrap      : one-cycle pulse at carrier terminal count
//   pwm_out   : registered comparator result (carrier <= latched ref)
//   busy      : high while running or stopping
module pwm_sequencer #(
  parameter int unsigned W          = 8,
  parameter int unsigned RST_PERIOD = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  pwm_sequencer_if.slave      cfg,
  input  logic [W-1:0]        ref_in,
  output logic [W-1:0]        carrier,
  output logic [1:0]          sel_out,
  output logic                wrap,
  output logic                pwm_out,
  output logic                busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StStop = 2'd2;

  localparam logic [W-1:0] RstPeriod = W'(RST_PERIOD);
  localparam logic [W-1:0] MinPeriod = W'(1);

  logic [1:0]   state_q, state_d;
  logic [W-1:0] carrier_q, carrier_d;
  logic [W-1:0] per_q, per_d;
  logic [1:0]   sel_q, sel_d;
  logic [W-1:0] pend_per_q, pend_per_d;
  logic [1:0]   pend_sel_q, pend_sel_d;
  logic         pend_vld_q, pend_vld_d;
  logic [W-1:0] ref_q, ref_d;
  logic         pwm_q, pwm_d;

  logic running;
  logic wrap_now;
  logic accept;

  assign running       = (state_q != StIdle);
  assign wrap_now      = running && (carrier_q == per_q);
  assign accept        = cfg.cfg_valid && !pend_vld_q;

  assign cfg.cfg_ready = !pend_vld_q;
  assign carrier       = carrier_q;
  assign sel_out       = sel_q;
  assign wrap          = wrap_now;
  assign pwm_out       = pwm_q;
  assign busy          = running;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en) state_d = StRun;
      StRun:   if (!en) state_d = StStop;
      StStop: begin
        if (en)            state_d = StRun;
        else if (wrap_now) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    carrier_d  = '0;
    ref_d      = ref_q;
    per_d      = per_q;
    sel_d      = sel_q;
    pend_per_d = pend_per_q;
    pend_sel_d = pend_sel_q;
    pend_vld_d = pend_vld_q;

    if (running && !wrap_now) carrier_d = carrier_q + MinPeriod;

    // Reference is sampled once per period so mid-period changes are invisible.
    if (wrap_now || (!running && en)) ref_d = ref_in;

    // Only a cfg already pending before this cycle can be applied; a cfg accepted
    // on a wrap cycle waits for the next wrap.
    if (pend_vld_q && (wrap_now || !running)) begin
      per_d      = pend_per_q;
      sel_d      = pend_sel_q;
      pend_vld_d = 1'b0;
    end

    if (accept) begin
      pend_per_d = (cfg.cfg_period == '0) ? MinPeriod : cfg.cfg_period;
      pend_sel_d = cfg.cfg_sel;
      pend_vld_d = 1'b1;
    end

    // Output 0 when either the sampled or the following cycle is idle.
    pwm_d = running && (state_d != StIdle) && (carrier_q <= ref_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      carrier_q  <= '0;
      per_q      <= RstPeriod;
      sel_q      <= 2'd0;
      pend_per_q <= '0;
      pend_sel_q <= 2'd0;
      pend_vld_q <= 1'b0;
      ref_q      <= '0;
      pwm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      carrier_q  <= carrier_d;
      per_q      <= per_d;
      sel_q      <= sel_d;
      pend_per_q <= pend_per_d;
      pend_sel_q <= pend_sel_d;
      pend_vld_q <= pend_vld_d;
      ref_q      <= ref_d;
      pwm_q      <= pwm_d;
    end
  end

endmodule

// File: doc/pwm_sequencer.md
PWM_SEQUENCER -- requirements
Module: pwm_sequencer

Interface
REQ-001 SHALL have parameter W, default 8, meaning carrier/reference bit width.
REQ-002 SHALL have parameter RST_PERIOD, default 255, meaning carrier terminal count after reset.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  run request; level-sensitive.
REQ-006 SHALL have port cfg_valid  input  1  new configuration offered.
REQ-007 SHALL have port cfg_ready  output  1  configuration slot free.
REQ-008 SHALL have port cfg_period  input  W  carrier terminal count requested.
REQ-009 SHALL have port cfg_sel  input  2  waveform select requested.
REQ-010 SHALL have port ref_in  input  W  reference sample (sine generator or ADC).
REQ-011 SHALL have port carrier  output  W  sawtooth carrier value.
REQ-012 SHALL have port sel_out  output  2  active waveform select to generator.
REQ-013 SHALL have port wrap  output  1  one-cycle pulse at carrier terminal count.
REQ-014 SHALL have port pwm_out  output  1  registered comparator result.
REQ-015 SHALL have port busy  output  1  high in RUN or STOP.

Function
REQ-016 SHALL implement states IDLE, RUN, STOP.
REQ-017 IDLE -> RUN when en=1; carrier starts at 0 on the first RUN cycle.
REQ-018 RUN -> STOP when en=0; STOP -> RUN when en=1 before wrap (stop cancelled, carrier continues); STOP -> IDLE on the cycle wrap=1.
REQ-019 In RUN/STOP carrier SHALL increment by 1 each cycle and reload 0 the cycle after carrier == active period; in IDLE carrier SHALL hold 0.
REQ-020 wrap SHALL be 1 exactly on cycles where state is RUN/STOP and carrier == active period; 0 otherwise.
REQ-021 Active period and active sel SHALL be shadowed; cfg accepted on cycle cfg_valid && cfg_ready, stored in pending register, cfg_ready drops next cycle.
REQ-022 Pending cfg SHALL become active on the next wrap cycle (effective from following carrier value 0), or on the cycle after acceptance if in IDLE; cfg_ready returns to 1 the cycle after application.
REQ-023 cfg accepted on the same cycle as wrap SHALL NOT apply at that wrap; applies at the following wrap.
REQ-024 cfg_valid while cfg_ready=0 SHALL be ignored; no overwrite of pending cfg.
REQ-025 cfg_period of 0 SHALL be stored as 1 (minimum two-count carrier).
REQ-026 ref_in SHALL be latched into compare register on every wrap and on IDLE->RUN transition; mid-period ref_in changes SHALL NOT affect pwm_out.
REQ-027 pwm_out SHALL be registered: 0 if carrier > latched ref, else 1, one clk after carrier value; forced 0 in IDLE.
REQ-028 Comparison SHALL be unsigned W-bit; ref == carrier yields 1.
REQ-029 sel_out SHALL equal active sel at all times, including IDLE.

Reset
REQ-030 rst=1 SHALL asynchronously force: state IDLE, carrier 0, wrap 0, pwm_out 0, busy 0, cfg_ready 1, pending cleared, active period RST_PERIOD, sel_out 0, latched ref 0.
REQ-031 rst asserted mid-period SHALL discard pending cfg; operation restarts only after rst=0 and en=1.

Verification
REQ-032 Reset then en=1, ref_in=128, period 255 -> carrier 0..255 repeating, wrap every 256 cycles, pwm_out 1 for carrier 0..128 (129 cycles) and 0 for 127 cycles, one-cycle lag.
REQ-033 In RUN, cfg period=9 sel=2 mid-period -> cfg_ready low until wrap; old period finishes, then carrier 0..9, wrap every 10 cycles, sel_out=2 from the wrap.
REQ-034 cfg_valid on wrap cycle with period=3 -> one more full old period, then period 3; second cfg during pending ignored.
REQ-035 en=0 at carrier=100 (period 255) -> busy stays 1 to wrap at 255, then IDLE, carrier 0, pwm_out 0; repeat with en=1 again at carrier 200 -> no IDLE entry.
REQ-036 cfg_period=0 -> carrier alternates 0,1, wrap every 2 cycles; ref_in=0 -> pwm_out 1,0 pattern.
REQ-037 rst pulse at carrier=50 with cfg pending -> all outputs at reset values immediately, pending lost, period back to 255.
